dmem_bridge: RTL and testbench
==============================

# dmem_bridge

Data-memory bridge between the MEM stage of the 5-stage pipelined CPU datapath and a word-wide, variable-latency data bus. It turns the pipeline's single-cycle read/write strobes into a req/ack bus transaction and holds the pipeline with a stall flag until the transaction ends. It returns load data on the MEM-stage `mem_din` path and flags misaligned or malformed accesses.

## Interface

Parameters:
- `TIMEOUT_CYCLES`, default 64: maximum cycles `bus_req` stays asserted without `bus_ack` (1..255).

Ports:
- `clk`  in  1  main clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `mem_ren`  in  1  load request from the MEM stage.
- `mem_wen`  in  1  store request from the MEM stage.
- `mem_addr`  in  32  byte address from the MEM stage.
- `mem_dout`  in  32  store data from the MEM stage.
- `mem_din`  out  32  load data to the MEM stage.
- `mem_stall`  out  1  pipeline hold request, combinational.
- `mem_err`  out  1  one-cycle error pulse.
- `bus_req`  out  1  bus request.
- `bus_we`  out  1  bus write enable.
- `bus_addr`  out  32  word-aligned bus address.
- `bus_wdata`  out  32  bus write data.
- `bus_ack`  in  1  bus completion strobe.
- `bus_rdata`  in  32  bus read data, valid when `bus_ack`=1.

## Operation

- States: IDLE, REQ, DONE.
- IDLE, no access (`mem_ren`=`mem_wen`=0): stay in IDLE; `mem_stall`=0.
- IDLE, access present: `mem_stall`=1, then classify the access:
  - Valid access: exactly one of `mem_ren`/`mem_wen` is set and `mem_addr[1:0]`=0. Latch addr, wdata and we into `bus_addr`/`bus_wdata`/`bus_we`, then go to REQ.
  - Error access: both strobes set, or `mem_addr[1:0]`≠0. Go to DONE with error set. No bus cycle is issued. Latched `mem_din`=0.
- REQ: `bus_req`=1 and `mem_stall`=1. Address, data and we are held stable.
  - `bus_ack`=1: capture `bus_rdata` into the `mem_din` register (loads only; stores leave it unchanged), drop `bus_req`, go to DONE.
- DONE: `mem_stall`=0, so the pipeline advances on this edge. `mem_err` is high here if an error was recorded. Next state is always IDLE.
  - The strobes still visible in DONE belong to the completed access and are never re-issued.
- `mem_din` is a register. It holds the last load result until the next load completes.
- `bus_ack` outside REQ is ignored.

## Timing

- Reset (async assert): state=IDLE, `bus_req`=0, `bus_we`=0, `bus_addr`=0, `bus_wdata`=0, `mem_din`=0, `mem_err`=0, timeout counter=0.
- Reset deassertion is synchronous to `clk` externally.
- Reset mid-transaction drops `bus_req` immediately. The bus side must tolerate an abandoned request.
- Latency with `bus_ack` in the first REQ cycle: 3 MEM-stage cycles (IDLE detect, REQ, DONE).
- Each extra wait cycle on the bus adds one cycle of `mem_stall`.
- `mem_stall` = (IDLE & (`mem_ren`|`mem_wen`)) | REQ.
- Back-to-back accesses: DONE→IDLE, and the next instruction's strobes are detected in that IDLE cycle. No bubble beyond the IDLE detect cycle.
- Error access: IDLE (stall) → DONE (`mem_err`=1). 2 cycles, no bus activity.

## Configuration

- `DMEM_TIMEOUT_EN` defined:
  - An 8-bit counter clears on entry to REQ and increments each REQ cycle without ack.
  - When the count reaches `TIMEOUT_CYCLES`: drop `bus_req`, set `mem_din`=0 for loads, go to DONE with `mem_err`=1.
  - Ack in the same cycle as the limit wins: normal completion, no error.
- Undefined: no counter. REQ waits for `bus_ack` indefinitely. `TIMEOUT_CYCLES` is unused.

## Test plan

- Load 0x0000_0010, ack on 1st REQ cycle, `bus_rdata`=0x1234_5678 → `bus_we`=0, `bus_addr`=0x10, stall high 2 cycles, `mem_din`=0x1234_5678 in DONE, `mem_err`=0.
- Store 0x0000_0020 data 0xCAFE_F00D, ack after 4 wait cycles → `bus_we`=1, `bus_wdata` stable for the whole REQ, stall high 6 cycles, `mem_din` unchanged.
- Load at 0x0000_0022 → no `bus_req`, stall high 1 cycle, DONE with `mem_err`=1, `mem_din`=0.
- `mem_ren`=`mem_wen`=1 → same as the misaligned case. Two consecutive valid loads → two separate bus transactions, no duplicate issue in DONE.
- `DMEM_TIMEOUT_EN`, `TIMEOUT_CYCLES`=4, no ack → `bus_req` high exactly 4 cycles, then `mem_err`=1, `mem_din`=0. Ack on cycle 4 → success, no error.
- `rst_n` pulled low during REQ → `bus_req`=0 and all outputs at reset values asynchronously. After release, a new load completes normally.

Source files
------------

// File: rtl/dmem_bridge.sv
// dmem_bridge: turns MEM-stage read/write strobes into a req/ack word bus transaction, returns load data, flags bad accesses.
// Latency: 3 cycles (IDLE detect, REQ, DONE) with ack in the first REQ cycle; +1 cycle per bus wait cycle; error access 2 cycles.
// Backpressure: mem_stall holds the pipeline until DONE; define DMEM_TIMEOUT_EN to abandon a REQ after TIMEOUT_CYCLES unacked cycles.
module dmem_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_ren,
  input  logic        mem_wen,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_dout,
  output logic [31:0] mem_din,
  output logic        mem_stall,
  output logic        mem_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e      state_q;
  logic        bus_req_q;
  logic        bus_we_q;
  logic [31:0] bus_addr_q;
  logic [31:0] bus_wdata_q;
  logic [31:0] mem_din_q;
  logic        mem_err_q;

  logic        access_present;
  logic        access_valid;

  // An access is well formed only with exactly one strobe and a word-aligned address.
  assign access_present = mem_ren | mem_wen;
  assign access_valid   = (mem_ren ^ mem_wen) & (mem_addr[1:0] == 2'b00);

`ifdef DMEM_TIMEOUT_EN
  localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT_CYCLES);

  logic [7:0] tmo_cnt_q;
  logic [7:0] tmo_cnt_d;
  logic       tmo_hit;

  // The count after this REQ cycle; hitting the limit means bus_req has been up TIMEOUT_CYCLES cycles.
  assign tmo_cnt_d = tmo_cnt_q + 8'd1;
  assign tmo_hit   = (tmo_cnt_d == TMO_LIMIT);
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

  // Transaction FSM; every bus- and pipeline-facing output except mem_stall is a register here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= 32'h0;
      bus_wdata_q <= 32'h0;
      mem_din_q   <= 32'h0;
      mem_err_q   <= 1'b0;
`ifdef DMEM_TIMEOUT_EN
      tmo_cnt_q   <= 8'd0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (access_present) begin
            if (access_valid) begin
              // Latch the request so the bus sees stable fields for the whole REQ phase.
              bus_req_q   <= 1'b1;
              bus_we_q    <= mem_wen;
              bus_addr_q  <= {mem_addr[31:2], 2'b00};
              bus_wdata_q <= mem_dout;
`ifdef DMEM_TIMEOUT_EN
              tmo_cnt_q   <= 8'd0;
`endif
              state_q     <= ST_REQ;
            end else begin
              // Malformed access: never reaches the bus, reports through mem_err in DONE.
              mem_din_q <= 32'h0;
              mem_err_q <= 1'b1;
              state_q   <= ST_DONE;
            end
          end
        end

        ST_REQ: begin
          if (bus_ack) begin
            // Ack takes priority over an expiring timeout in the same cycle.
            if (!bus_we_q) begin
              mem_din_q <= bus_rdata;
            end
            bus_req_q <= 1'b0;
            state_q   <= ST_DONE;
          end
`ifdef DMEM_TIMEOUT_EN
          else if (tmo_hit) begin
            bus_req_q <= 1'b0;
            if (!bus_we_q) begin
              mem_din_q <= 32'h0;
            end
            mem_err_q <= 1'b1;
            tmo_cnt_q <= tmo_cnt_d;
            state_q   <= ST_DONE;
          end else begin
            tmo_cnt_q <= tmo_cnt_d;
          end
`endif
        end

        ST_DONE: begin
          // Strobes still visible here belong to the finished access; go back and wait for the next one.
          mem_err_q <= 1'b0;
          state_q   <= ST_IDLE;
        end

        default: begin
          bus_req_q <= 1'b0;
          mem_err_q <= 1'b0;
          state_q   <= ST_IDLE;
        end
      endcase
    end
  end

  // Stall covers the detect cycle and every REQ cycle; DONE releases the pipeline.
  assign mem_stall = ((state_q == ST_IDLE) & access_present) | (state_q == ST_REQ);

  assign mem_din   = mem_din_q;
  assign mem_err   = mem_err_q;
  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_dmem_bridge.sv
// tb_dmem_bridge: randomized and directed accesses checked against a per-access outcome model.
// Latency: stimulus paced one access at a time, back-to-back or with idle gaps.
// Backpressure: bus responder inserts a chosen number of wait cycles before ack.
module tb_dmem_bridge;

  localparam int TMO = 4;
`ifdef DMEM_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_ren = 1'b0;
  logic        mem_wen = 1'b0;
  logic [31:0] mem_addr = 32'h0;
  logic [31:0] mem_dout = 32'h0;
  logic [31:0] mem_din;
  logic        mem_stall;
  logic        mem_err;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = 32'h0;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] model_din = 32'h0;

  dmem_bridge #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mem_ren   (mem_ren),
    .mem_wen   (mem_wen),
    .mem_addr  (mem_addr),
    .mem_dout  (mem_dout),
    .mem_din   (mem_din),
    .mem_stall (mem_stall),
    .mem_err   (mem_err),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_ack   (bus_ack),
    .bus_rdata (bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Idle cycles with no strobes; stray acks must be ignored.
  task automatic idle(input int n);
    mem_ren = 1'b0;
    mem_wen = 1'b0;
    for (int i = 0; i < n; i++) begin
      mem_addr = $urandom;
      bus_ack  = 1'($urandom_range(0, 1));
      #1;
      check32("idle_stall", 32'(mem_stall), 32'h0);
      check32("idle_req", 32'(bus_req), 32'h0);
      @(posedge clk); #1;
    end
    bus_ack = 1'b0;
  endtask

  // One MEM-stage access; entered and left at posedge+1 with the DUT expected in IDLE.
  task automatic do_access(input logic ren, input logic wen, input logic [31:0] addr,
                           input logic [31:0] wdata, input int wait_n, input logic [31:0] rdata);
    bit          err;
    bit          tmo;
    bit          done;
    int          exp_req;
    int          exp_stall;
    int          n_stall;
    int          n_req;
    int          cyc;
    logic        exp_err;
    logic [31:0] exp_din;

    err = (ren && wen) || (addr[1:0] != 2'b00);
    tmo = !err && TMO_EN && (wait_n >= TMO);
    if (err) begin
      exp_req = 0; exp_stall = 1; exp_err = 1'b1; exp_din = 32'h0;
    end else if (tmo) begin
      exp_req = TMO; exp_stall = TMO + 1; exp_err = 1'b1; exp_din = ren ? 32'h0 : model_din;
    end else begin
      exp_req = wait_n + 1; exp_stall = wait_n + 2; exp_err = 1'b0; exp_din = ren ? rdata : model_din;
    end

    n_stall = 0; n_req = 0; cyc = 0; done = 1'b0;
    mem_ren = ren; mem_wen = wen; mem_addr = addr; mem_dout = wdata;
    while (!done && cyc < exp_stall + 8) begin
      #1;
      if (mem_stall) n_stall++;
      if (bus_req) begin
        n_req++;
        check32("bus_we", 32'(bus_we), 32'(wen));
        check32("bus_addr", bus_addr, addr);
        check32("bus_wdata", bus_wdata, wdata);
        bus_ack   = (n_req > wait_n);
        bus_rdata = bus_ack ? rdata : $urandom;
        mem_addr  = $urandom;
        mem_dout  = $urandom;
      end else begin
        bus_ack   = 1'($urandom_range(0, 1));
        bus_rdata = $urandom;
        if (mem_stall) check32("err_early", 32'(mem_err), 32'h0);
      end
      if (!mem_stall) begin
        done = 1'b1;
        check32("done_err", 32'(mem_err), 32'(exp_err));
        check32("done_din", mem_din, exp_din);
      end
      @(posedge clk); #1;
      cyc++;
    end
    check32("done_reached", 32'(done), 32'h1);
    check32("stall_cycles", n_stall, exp_stall);
    check32("req_cycles", n_req, exp_req);
    model_din = exp_din;
    mem_ren = 1'b0;
    mem_wen = 1'b0;
    bus_ack = 1'b0;
  endtask

  initial begin
    int          sel;
    logic        r;
    logic        w;
    logic [31:0] a;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check32("rst_bus_req", 32'(bus_req), 32'h0);
    check32("rst_bus_we", 32'(bus_we), 32'h0);
    check32("rst_bus_addr", bus_addr, 32'h0);
    check32("rst_bus_wdata", bus_wdata, 32'h0);
    check32("rst_mem_din", mem_din, 32'h0);
    check32("rst_mem_err", 32'(mem_err), 32'h0);
    check32("rst_mem_stall", 32'(mem_stall), 32'h0);
    rst_n = 1'b1;
    idle(2);

    // Directed cases.
    do_access(1'b1, 1'b0, 32'h0000_0010, $urandom, 0, 32'h1234_5678);
    idle(1);
    do_access(1'b0, 1'b1, 32'h0000_0020, 32'hCAFE_F00D, 4, $urandom);
    idle(1);
    do_access(1'b1, 1'b0, 32'h0000_0022, $urandom, 0, $urandom);
    do_access(1'b1, 1'b0, 32'h0000_0030, $urandom, 1, 32'hA5A5_0001);
    do_access(1'b1, 1'b1, 32'h0000_0040, $urandom, 0, $urandom);
    do_access(1'b1, 1'b0, 32'h0000_0100, $urandom, 1, 32'h1111_2222);
    do_access(1'b1, 1'b0, 32'h0000_0104, $urandom, 0, 32'h3333_4444);
    do_access(1'b1, 1'b0, 32'h0000_0200, $urandom, TMO - 1, 32'h5555_6666);
    do_access(1'b1, 1'b0, 32'h0000_0204, $urandom, TMO + 2, 32'h7777_8888);
    do_access(1'b0, 1'b1, 32'h0000_0208, $urandom, TMO, $urandom);
    do_access(1'b1, 1'b0, 32'h0000_020C, $urandom, 40, 32'h9999_AAAA);
    idle(1);

    // Reset pulled in the middle of a REQ phase.
    do_access(1'b1, 1'b0, 32'h0000_0280, $urandom, 0, 32'hDEAD_BEEF);
    mem_ren = 1'b1; mem_addr = 32'h0000_0300; mem_dout = 32'h0BAD_CAFE; bus_ack = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check32("rst_mid_pre_req", 32'(bus_req), 32'h1);
    rst_n = 1'b0;
    mem_ren = 1'b0;
    #1;
    check32("rst_mid_bus_req", 32'(bus_req), 32'h0);
    check32("rst_mid_bus_we", 32'(bus_we), 32'h0);
    check32("rst_mid_bus_addr", bus_addr, 32'h0);
    check32("rst_mid_bus_wdata", bus_wdata, 32'h0);
    check32("rst_mid_mem_din", mem_din, 32'h0);
    check32("rst_mid_mem_err", 32'(mem_err), 32'h0);
    check32("rst_mid_stall", 32'(mem_stall), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_din = 32'h0;
    idle(1);
    do_access(1'b1, 1'b0, 32'h0000_0300, $urandom, 2, 32'hFEED_0042);

    // Randomized accesses, mixing back-to-back issue and idle gaps.
    for (int k = 0; k < 60; k++) begin
      sel = $urandom_range(0, 9);
      r = (sel < 5) || (sel == 9);
      w = (sel >= 5);
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      do_access(r, w, a, $urandom, $urandom_range(0, 7), $urandom);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
